// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx
// Serialises OSD command transactions onto a framed 16-bit word bus.
// A transaction is a GUARD-cycle settle period with io_osd high, one or
// more word slots (io_din held, io_strobe low for STB_LO then high for
// STB_HI), a GUARD-cycle tail with io_osd still high and a GUARD-cycle
// idle-low period. Buffer writes fetch each byte from an external source
// with a one-cycle FETCH before its slot.
//
// Ports:
//   clk_sys, rst_n           clock, asynchronous active-low reset
//   req, op                  start request and transaction type
//   line, wr_len             buffer-write start line and byte count
//   infox/infoy/infow/infoh  info payload parameters
//   rot                      rotation payload parameter
//   abort                    synchronous cancel of a running transaction
//   rd_en, rd_addr, rd_data  byte source read port
//   io_osd, io_strobe, io_din  OSD frame, word strobe, word data
//   busy, done               transaction in progress, completion pulse
module osd_cmd_tx #(
    parameter int STB_LO = 2,
    parameter int STB_HI = 2,
    parameter int GUARD  = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [4:0]  line,
    input  logic [12:0] wr_len,
    input  logic [11:0] infox,
    input  logic [11:0] infoy,
    input  logic [5:0]  infow,
    input  logic [5:0]  infoh,
    input  logic [1:0]  rot,
    input  logic        abort,
    output logic        rd_en,
    output logic [12:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din,
    output logic        busy,
    output logic        done
);

    localparam int SLOT_LEN = STB_LO + STB_HI;

    typedef enum logic [2:0] {IDLE, PRE, FETCH, SLOT, POST_HI, POST_LO} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  op_q;
    logic [4:0]  line_q;
    logic [11:0] infox_q;
    logic [11:0] infoy_q;
    logic [5:0]  infow_q;
    logic [5:0]  infoh_q;
    logic [1:0]  rot_q;
    logic [2:0]  widx;
    logic [13:0] rem;
    logic [12:0] ptr;

    logic [13:0] limit;
    logic [13:0] n_req;
    logic [15:0] cmd_word;
    logic [15:0] payload_word;
    logic        enter_lo;

    // Byte count is clamped so the write never runs past the end of the
    // 8 KiB buffer; the command word and payload words come from the
    // request fields latched at acceptance.
    always_comb begin
        limit = 14'd8192 - 14'({line, 8'h00});
        n_req = ({1'b0, wr_len} < limit) ? {1'b0, wr_len} : limit;

        case (op_q)
            2'd0:    cmd_word = 16'h0040;
            2'd1:    cmd_word = 16'h0041;
            2'd2:    cmd_word = 16'h0045;
            default: cmd_word = {11'b0, 3'b001, line_q};
        endcase

        case (widx)
            3'd0:    payload_word = {4'b0, infox_q};
            3'd1:    payload_word = {4'b0, infoy_q};
            3'd2:    payload_word = {10'b0, infow_q};
            3'd3:    payload_word = {10'b0, infoh_q};
            default: payload_word = {14'b0, rot_q};
        endcase

        // Both a cancel and the normal end of the high tail lead into the
        // idle-low period, so they share one entry path.
        enter_lo = (abort && (state == PRE || state == FETCH || state == SLOT)) ||
                   (state == POST_HI && cnt == 16'd0);
    end

    // Transaction sequencer. Every output is a register loaded with the
    // value it must show in the cycle the FSM is about to enter, so the
    // strobe pattern inside a slot is derived from the remaining count.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            line_q    <= '0;
            infox_q   <= '0;
            infoy_q   <= '0;
            infow_q   <= '0;
            infoh_q   <= '0;
            rot_q     <= '0;
            widx      <= '0;
            rem       <= '0;
            ptr       <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            io_osd    <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            if (enter_lo) begin
                state     <= POST_LO;
                cnt       <= 16'(GUARD - 1);
                io_osd    <= 1'b0;
                io_strobe <= 1'b0;
                io_din    <= '0;
                done      <= (GUARD == 1);
            end else begin
                case (state)
                    IDLE: begin
                        if (req && !abort) begin
                            op_q      <= op;
                            line_q    <= line;
                            infox_q   <= infox;
                            infoy_q   <= infoy;
                            infow_q   <= infow;
                            infoh_q   <= infoh;
                            rot_q     <= rot;
                            rem       <= n_req;
                            ptr       <= {line, 8'h00};
                            widx      <= '0;
                            state     <= PRE;
                            cnt       <= 16'(GUARD - 1);
                            busy      <= 1'b1;
                            io_osd    <= 1'b1;
                            io_strobe <= 1'b0;
                            io_din    <= '0;
                        end
                    end
                    PRE: begin
                        if (cnt == 16'd0) begin
                            state     <= SLOT;
                            cnt       <= 16'(SLOT_LEN - 1);
                            io_din    <= cmd_word;
                            io_strobe <= 1'b0;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    SLOT: begin
                        if (cnt != 16'd0) begin
                            // The last STB_HI cycles of the slot are high.
                            io_strobe <= (cnt <= 16'(STB_HI));
                            cnt       <= cnt - 16'd1;
                        end else begin
                            io_strobe <= 1'b0;
                            if (op_q == 2'd3 && rem != 14'd0) begin
                                state   <= FETCH;
                                rd_en   <= 1'b1;
                                rd_addr <= ptr;
                                ptr     <= ptr + 13'd1;
                                rem     <= rem - 14'd1;
                            end else if ((op_q == 2'd1 || op_q == 2'd2) && widx != 3'd5) begin
                                io_din <= payload_word;
                                widx   <= widx + 3'd1;
                                cnt    <= 16'(SLOT_LEN - 1);
                            end else begin
                                state <= POST_HI;
                                cnt   <= 16'(GUARD - 1);
                            end
                        end
                    end
                    FETCH: begin
                        state  <= SLOT;
                        io_din <= {8'h00, rd_data};
                        cnt    <= 16'(SLOT_LEN - 1);
                    end
                    POST_HI: begin
                        cnt <= cnt - 16'd1;
                    end
                    POST_LO: begin
                        if (cnt == 16'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt  <= cnt - 16'd1;
                            done <= (cnt == 16'd1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
